// File: rtl/step_ctrl_pkg.sv
// Shared types and default parameter values for the generation-step controller
// and its button debouncer.
package step_ctrl_pkg;

  typedef enum logic {IDLE, BUSY} step_state_t;

  localparam int GEN_W_DEF    = 16;
  localparam int MISS_W_DEF   = 8;
  localparam int DEBOUNCE_DEF = 500000;

endpackage

// File: rtl/step_ctrl_if.sv
// Step request/acknowledge handshake between the step controller (master)
// and the compute engine (slave).
interface step_ctrl_if;

  logic step_req;
  logic busy;
  logic step_ack;

  modport master (
    output step_req,
    output busy,
    input  step_ack
  );

  modport slave (
    input  step_req,
    input  busy,
    output step_ack
  );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, hold-time debounce counter and a
// single registered press pulse per accepted press.
module btn_debounce
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
    end
  end

  // Counter parks at CNT_MAX so a held button cannot produce a second pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!sync_2) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      press <= 1'b0;
    end else begin
      press <= sync_2 && (cnt == CNT_PRE);
    end
  end

endmodule

// File: rtl/step_ctrl.sv
// Generation-step controller: turns divider ticks (running) or debounced button
// presses (paused) into held step requests, counting completions and misses.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int GEN_W           = GEN_W_DEF,
  parameter int MISS_W          = MISS_W_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_lvl,
  input  logic              run,
  input  logic              step_btn,
  input  logic              clr,
  step_ctrl_if.master       hs,
  output logic [GEN_W-1:0]  gen_count,
  output logic [MISS_W-1:0] missed_count
);

  step_state_t state;
  step_state_t state_nxt;

  logic tick_prev;
  logic armed;
  logic tick_rise_q;
  logic press;
  logic trig;
  logic gen_inc;
  logic miss_inc;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (step_btn),
    .press   (press)
  );

  // The rise is registered so both trigger sources reach the FSM one cycle
  // late; armed masks the first post-reset sample so a level that was already
  // high when reset released is not mistaken for a fresh edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_prev   <= 1'b0;
      armed       <= 1'b0;
      tick_rise_q <= 1'b0;
    end else begin
      tick_prev   <= tick_lvl;
      armed       <= 1'b1;
      tick_rise_q <= armed & tick_lvl & ~tick_prev;
    end
  end

  assign trig = run ? tick_rise_q : press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gen_inc   = 1'b0;
    miss_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (hs.step_ack) begin
          state_nxt = IDLE;
          gen_inc   = 1'b1;
        end
        if (trig) begin
          miss_inc = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gen_count <= '0;
    end else if (clr) begin
      gen_count <= '0;
    end else if (gen_inc) begin
      gen_count <= gen_count + GEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      missed_count <= '0;
    end else if (clr) begin
      missed_count <= '0;
    end else if (miss_inc && (missed_count != '1)) begin
      missed_count <= missed_count + MISS_W'(1);
    end
  end

  assign hs.step_req = (state == BUSY);
  assign hs.busy     = hs.step_req;

endmodule

// File: tb/tb_step_ctrl.sv
// Self-checking bench for step_ctrl: vector table, directed corner sequences and
// randomized traffic against an event-level reference model.
module tb_step_ctrl;

  localparam int GEN_W  = 4;
  localparam int MISS_W = 2;
  localparam int DEB    = 4;
  localparam int GEN_MOD  = 1 << GEN_W;
  localparam int MISS_MAX = (1 << MISS_W) - 1;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic tick_lvl = 1'b0;
  logic run      = 1'b0;
  logic step_btn = 1'b0;
  logic clr      = 1'b0;
  logic [GEN_W-1:0]  gen_count;
  logic [MISS_W-1:0] missed_count;

  int n_cmp = 0;
  int n_err = 0;

  step_ctrl_if hs ();

  step_ctrl #(
    .GEN_W           (GEN_W),
    .MISS_W          (MISS_W),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_lvl     (tick_lvl),
    .run          (run),
    .step_btn     (step_btn),
    .clr          (clr),
    .hs           (hs),
    .gen_count    (gen_count),
    .missed_count (missed_count)
  );

  always #5 clk = ~clk;

  // Reference model: edges since reset, recent tick samples, and the length of
  // the button's current high run (a press fires when a run reaches DEB).
  int m_n;
  bit m_t1, m_t2;
  int m_r1, m_r2, m_r3;
  bit m_busy;
  int m_gen, m_miss;

  typedef struct {
    logic tick;
    logic run;
    logic ack;
    logic clr;
    logic req;
    int   gen;
    int   miss;
  } vec_t;

  vec_t vecs[18];

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_n = 0; m_t1 = 0; m_t2 = 0;
    m_r1 = 0; m_r2 = 0; m_r3 = 0;
    m_busy = 0; m_gen = 0; m_miss = 0;
  endtask

  task automatic modelStep();
    bit rise, press, trig;
    int rl;
    rise  = (m_n >= 2) && m_t1 && !m_t2;
    press = (m_r3 == DEB);
    trig  = run ? rise : press;
    if (m_busy) begin
      if (trig && m_miss < MISS_MAX) m_miss++;
      if (hs.step_ack) begin
        m_busy = 0;
        m_gen  = (m_gen + 1) % GEN_MOD;
      end
    end else if (trig) begin
      m_busy = 1;
    end
    if (clr) begin
      m_gen  = 0;
      m_miss = 0;
    end
    rl = step_btn ? ((m_r1 > 1000) ? m_r1 : m_r1 + 1) : 0;
    m_r3 = m_r2; m_r2 = m_r1; m_r1 = rl;
    m_t2 = m_t1; m_t1 = tick_lvl;
    m_n++;
  endtask

  task automatic checkModel();
    checkOutput("model_step_req", 32'(hs.step_req), 32'(m_busy));
    checkOutput("model_busy", 32'(hs.busy), 32'(m_busy));
    checkOutput("model_gen_count", 32'(gen_count), m_gen);
    checkOutput("model_missed_count", 32'(missed_count), m_miss);
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    modelStep();
    checkModel();
  endtask

  task automatic doReset();
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput("reset_step_req", 32'(hs.step_req), 0);
    checkOutput("reset_gen_count", 32'(gen_count), 0);
    checkOutput("reset_missed_count", 32'(missed_count), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  // One full tick-driven generation; tick is low on entry and exit.
  task automatic oneGen();
    tick_lvl = 1'b1; applyStimulus(); applyStimulus();
    tick_lvl = 1'b0; applyStimulus();
    hs.step_ack = 1'b1; applyStimulus();
    hs.step_ack = 1'b0; applyStimulus();
  endtask

  initial begin
    int lat;
    int btn_hold, tick_hold;
    hs.step_ack = 1'b0;
    #2;
    doReset();

    // Vector table: run=1 traffic covering accept, ack, drop-on-ack, idle ack,
    // clear interactions and mode toggling while a tick level is high.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};

    run = 1'b1;
    idle(3);
    for (int i = 0; i < 18; i++) begin
      tick_lvl    = vecs[i].tick;
      run         = vecs[i].run;
      hs.step_ack = vecs[i].ack;
      clr         = vecs[i].clr;
      applyStimulus();
      checkOutput($sformatf("vec%0d_step_req", i), 32'(hs.step_req), 32'(vecs[i].req));
      checkOutput($sformatf("vec%0d_gen_count", i), 32'(gen_count), vecs[i].gen);
      checkOutput($sformatf("vec%0d_missed_count", i), 32'(missed_count), vecs[i].miss);
    end
    tick_lvl = 1'b0; hs.step_ack = 1'b0; clr = 1'b0;

    // Free-run latency and generation counter wrap.
    doReset();
    run = 1'b1;
    idle(9);
    tick_lvl = 1'b1; applyStimulus();
    checkOutput("tick_latency_early", 32'(hs.step_req), 0);
    applyStimulus();
    checkOutput("tick_latency", 32'(hs.step_req), 1);
    tick_lvl = 1'b0; idle(2);
    hs.step_ack = 1'b1; applyStimulus();
    hs.step_ack = 1'b0;
    checkOutput("ack_drops_req", 32'(hs.step_req), 0);
    checkOutput("first_gen", 32'(gen_count), 1);
    for (int i = 0; i < 15; i++) oneGen();
    checkOutput("gen_wrap", 32'(gen_count), 0);

    // Overrun: five rises with the ack withheld.
    doReset();
    run = 1'b1;
    idle(3);
    for (int i = 0; i < 5; i++) begin
      tick_lvl = 1'b1; idle(2);
      tick_lvl = 1'b0; idle(2);
    end
    checkOutput("overrun_req_held", 32'(hs.step_req), 1);
    checkOutput("overrun_miss_sat", 32'(missed_count), MISS_MAX);
    hs.step_ack = 1'b1; applyStimulus();
    hs.step_ack = 1'b0; applyStimulus();
    checkOutput("overrun_gen", 32'(gen_count), 1);

    // Single-step: short press rejected, long press yields one request.
    doReset();
    run = 1'b0;
    idle(3);
    step_btn = 1'b1; idle(3);
    step_btn = 1'b0; idle(10);
    checkOutput("short_press_no_req", 32'(hs.step_req), 0);
    step_btn = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus();
      if (hs.step_req && lat == 0) lat = i;
    end
    checkOutput("btn_latency", lat, 7);
    step_btn = 1'b0; idle(3);
    hs.step_ack = 1'b1; applyStimulus();
    hs.step_ack = 1'b0; idle(8);
    checkOutput("one_press_one_req", 32'(hs.step_req), 0);
    checkOutput("press_gen", 32'(gen_count), 1);
    for (int i = 0; i < 3; i++) begin
      tick_lvl = 1'b1; idle(2);
      tick_lvl = 1'b0; idle(2);
    end
    checkOutput("paused_tick_no_req", 32'(hs.step_req), 0);
    checkOutput("paused_tick_no_miss", 32'(missed_count), 0);

    // Simultaneous clear+ack, then a rise landing on the ack cycle.
    doReset();
    run = 1'b1;
    idle(3);
    for (int i = 0; i < 5; i++) oneGen();
    checkOutput("gen_before_clr", 32'(gen_count), 5);
    tick_lvl = 1'b1; idle(2);
    tick_lvl = 1'b0; applyStimulus();
    hs.step_ack = 1'b1; clr = 1'b1; applyStimulus();
    hs.step_ack = 1'b0; clr = 1'b0;
    checkOutput("clr_ack_gen", 32'(gen_count), 0);
    checkOutput("clr_ack_idle", 32'(hs.step_req), 0);
    tick_lvl = 1'b1; idle(2);
    tick_lvl = 1'b0; applyStimulus();
    tick_lvl = 1'b1; applyStimulus();
    hs.step_ack = 1'b1; applyStimulus();
    hs.step_ack = 1'b0; tick_lvl = 1'b0; idle(2);
    checkOutput("ack_cycle_drop_miss", 32'(missed_count), 1);
    checkOutput("ack_cycle_no_new_req", 32'(hs.step_req), 0);

    // Reset while busy with tick held high across the release.
    tick_lvl = 1'b1; idle(2);
    checkOutput("busy_before_reset", 32'(hs.step_req), 1);
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset_req", 32'(hs.step_req), 0);
    checkOutput("async_reset_miss", 32'(missed_count), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(4);
    checkOutput("no_req_after_release_high", 32'(hs.step_req), 0);
    tick_lvl = 1'b0; applyStimulus();
    tick_lvl = 1'b1; idle(2);
    checkOutput("req_on_next_rise", 32'(hs.step_req), 1);
    tick_lvl = 1'b0;
    hs.step_ack = 1'b1; applyStimulus();
    hs.step_ack = 1'b0;

    // Randomized traffic against the reference model.
    btn_hold  = 0;
    tick_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (btn_hold == 0) begin
        step_btn = 1'($urandom_range(0, 1));
        btn_hold = $urandom_range(1, 9);
      end else begin
        btn_hold--;
      end
      if (tick_hold == 0) begin
        tick_lvl  = ~tick_lvl;
        tick_hold = $urandom_range(1, 5);
      end else begin
        tick_hold--;
      end
      if ($urandom_range(0, 99) == 0) run = ~run;
      hs.step_ack = ($urandom_range(0, 99) < 30);
      clr         = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 499) == 0) doReset();
      else applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/step_ctrl.md
# step_ctrl

Generation-step controller sitting directly downstream of the clock divider. It turns the divider's slow `clk_en` square wave into single step requests for the compute engine while running. It turns debounced push-button presses into single requests while paused. Requests are held under a req/ack handshake, completed generations are counted, and triggers that arrive while a step is still outstanding are counted as missed.

## Interface
Parameters:
- `GEN_W`, default 16: width of the generation counter.
- `MISS_W`, default 8: width of the missed-trigger counter.
- `DEBOUNCE_CYCLES`, default 500000: consecutive high cycles required to accept a button press (10 ms at 50 MHz).

Ports:
- `clk`  in  1: system clock; same domain as the divider.
- `rst`  in  1: reset; one clock; reset is asynchronous and active-low.
- `tick_lvl`  in  1: divider `clk_en` output. It is a synchronous level, not a pulse.
- `run`  in  1: mode select. 1 = free-run on ticks, 0 = paused/single-step. Synchronous.
- `step_btn`  in  1: raw asynchronous push button, active-high.
- `clr`  in  1: synchronous one-cycle clear of both counters.
- `step_ack`  in  1: one-cycle pulse from the engine when the step is done.
- `step_req`  out  1: step request, held until acknowledged.
- `busy`  out  1: high while a request is outstanding; equal to `step_req`.
- `gen_count`  out  `GEN_W`: completed generations.
- `missed_count`  out  `MISS_W`: dropped triggers.

## Operation
- **Tick edge detect.** `tick_prev` register, reset 0. `tick_rise = tick_lvl & ~tick_prev`. No synchronizer is used, because `tick_lvl` is in the same clock domain.
- **Button path.**
  - 2-FF synchronizer, reset 0.
  - Debounce counter counts up while the synced level is 1 and clears to 0 when it is 0.
  - `press` is a one-cycle pulse when the counter reaches `DEBOUNCE_CYCLES`.
  - The counter then holds, so one press yields exactly one pulse; a new press requires a release first.
- **Trigger.** `trig = (run & tick_rise) | (~run & press)`. Ticks are ignored while paused and presses are ignored while running. Ignored events are never counted as missed.
- **FSM states.** IDLE and BUSY; reset state is IDLE.
  - IDLE & `trig`: go to BUSY, `step_req` set to 1.
  - BUSY & `step_ack`: go to IDLE, `step_req` set to 0, `gen_count` incremented.
  - BUSY & `trig` (including the cycle `step_ack` arrives): trigger dropped, `missed_count` incremented.
  - `step_ack` in IDLE: ignored, no count change.
- **Counter arithmetic.**
  - `gen_count` wraps from all-ones to 0.
  - `missed_count` saturates at all-ones.
- **Clear.**
  - `clr` zeroes both counters and does not affect the FSM or `step_req`.
  - `clr` and `step_ack` in the same cycle: `gen_count` becomes 0, and the FSM still returns to IDLE.
  - `clr` and a dropped trigger in the same cycle: `missed_count` becomes 0.
- **Mode change.**
  - Toggling `run` while BUSY leaves the outstanding request untouched.
  - Setting `run` while `tick_lvl` is already high does not trigger; the next rising edge does.
- **Reset.**
  - Asserting `rst` mid-step drops `step_req` immediately, with no ack needed.
  - The engine is reset by the same `rst`.

## Timing
- **Reset values.** `step_req`=0, `busy`=0, `gen_count`=0, `missed_count`=0, state IDLE. Synchronizer, debounce counter and `tick_prev` are all 0.
- **Tick latency.** `tick_lvl` first sampled high at edge N → `step_req` high after edge N+1.
- **Button latency.** 2 synchronizer cycles + `DEBOUNCE_CYCLES` + 1 register cycle.
- **Ack timing.**
  - `step_ack` sampled at edge M → `step_req` low and `gen_count` updated after edge M.
  - A new trigger can be accepted at edge M+1.
- **Outputs.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- **Package `step_ctrl_pkg`.**
  - `typedef enum logic {IDLE, BUSY} step_state_t`.
  - Default constants `GEN_W_DEF`, `MISS_W_DEF`, `DEBOUNCE_DEF`.
- **Sub-module `btn_debounce`.**
  - Contains the synchronizer, debounce counter and press pulse.
  - Parameter `DEBOUNCE_CYCLES`; ports `clk`, `rst`, `btn_raw`, `press`.
  - Reused by other button inputs in the design.
- **Top `step_ctrl`.** Edge detect, FSM, counters.

## Test plan
Run all scenarios with `DEBOUNCE_CYCLES`=4, `GEN_W`=4, `MISS_W`=2.
1. **Free-run.** `run`=1; `tick_lvl` rises at cycle 10; ack 3 cycles after `step_req` → `step_req` high at cycle 11, low after ack; `gen_count`=1. Repeat 16 times → `gen_count` wraps to 0.
2. **Overrun.** `run`=1; 5 tick rises with `step_ack` withheld → one request; `missed_count` saturates at 3 (4 drops); `gen_count`=1 after the final ack.
3. **Single-step.** `run`=0; button high 3 cycles then low → no request. Button high 20 cycles → exactly one request, first `step_req` 7 cycles after the button rises. Ticks during pause → no request and `missed_count` unchanged.
4. **Simultaneous events.** `clr`+`step_ack` in the same cycle with `gen_count`=5 → `gen_count`=0, IDLE. Tick rise in the ack cycle → `missed_count`+1 and no new request.
5. **Reset mid-step.** `rst` low while BUSY → `step_req`=0 asynchronously, all counters 0. After release with `tick_lvl` already high → no request until the next rising edge.
